// File: rtl/fibonacci_stream_pkg.sv
// Shared types and default sizes for the Fibonacci term streamer.
// Build option FIBONACCI_STREAM_SAT_EN is consumed by fib_step and fibonacci_stream.
package fibonacci_stream_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

endpackage

// File: rtl/fib_step.sv
// Combinational next-term adder with carry-out.
// With FIBONACCI_STREAM_SAT_EN defined, an overflowing sum is clamped to all-ones.
module fib_step
  import fibonacci_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] raw_sum;

  assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = raw_sum[WIDTH];

`ifdef FIBONACCI_STREAM_SAT_EN
  assign sum_o = carry_o ? {WIDTH{1'b1}} : raw_sum[WIDTH-1:0];
`else
  assign sum_o = raw_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/fibonacci_stream.sv
// Streams n_terms Fibonacci terms (1, 1, 2, 3, ...) over a valid/ready port.
// Define FIBONACCI_STREAM_SAT_EN to clamp and end the sequence on overflow; otherwise terms wrap.
//
// state | meaning
// IDLE  | waiting for start with non-zero n_terms
// RUN   | presenting a term that is not the final one
// LAST  | presenting the final term (out_last high)
module fibonacci_stream
  import fibonacci_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_terms_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             overflow_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             xfer;

  fib_step #(
    .WIDTH(WIDTH)
  ) u_fib_step (
    .a_i    (cur_q),
    .b_i    (prev_q),
    .sum_o  (sum),
    .carry_o(carry)
  );

  assign out_valid_o = (state_q != IDLE);
  assign out_last_o  = (state_q == LAST);
  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = cur_q;
  assign overflow_o  = ovf_q;
  assign xfer        = out_valid_o && out_ready_i;

  // cnt_q counts the terms still to come after the one being presented.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i && (n_terms_i != '0)) begin
          cur_d   = WIDTH'(1);
          prev_d  = '0;
          ovf_d   = 1'b0;
          cnt_d   = n_terms_i - CNT_W'(1);
          state_d = (n_terms_i == CNT_W'(1)) ? LAST : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          cur_d   = sum;
          prev_d  = cur_q;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? LAST : RUN;
          if (carry) begin
            ovf_d = 1'b1;
`ifdef FIBONACCI_STREAM_SAT_EN
            state_d = LAST;
`endif
          end
        end
      end
      LAST: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fibonacci_stream.sv
// Scoreboard bench for fibonacci_stream: a 32-bit and an 8-bit instance against a big-integer model.
// Honours FIBONACCI_STREAM_SAT_EN in the model so either build can be checked.
module tb_fibonacci_stream;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [7:0]  nt    [2];
  logic        ready [2];
  logic        valid [2];
  logic        last  [2];
  logic        busy  [2];
  logic        ovf   [2];
  logic [31:0] dat   [2];
  logic [31:0] data32;
  logic [7:0]  data8;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   errors = 0;
  int   beats [2];
  logic stall_p [2];
  logic [31:0] held_d [2];
  logic        held_l [2];
  exp_t mon_e;

  assign dat[0] = data32;
  assign dat[1] = {24'h0, data8};

  always #5 clk = ~clk;

  fibonacci_stream #(.WIDTH(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .start_i(start[0]), .n_terms_i(nt[0]),
    .out_valid_o(valid[0]), .out_ready_i(ready[0]), .out_data_o(data32),
    .out_last_o(last[0]), .busy_o(busy[0]), .overflow_o(ovf[0])
  );

  fibonacci_stream #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start[1]), .n_terms_i(nt[1]),
    .out_valid_o(valid[1]), .out_ready_i(ready[1]), .out_data_o(data8),
    .out_last_o(last[1]), .busy_o(busy[1]), .overflow_o(ovf[1])
  );

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: true Fibonacci values (saturated far above any WIDTH) decide overflow,
  // while the emitted value is the term reduced modulo 2^W or clamped in the saturating build.
  task automatic model_push(int sel, int n, output int len);
    int          w;
    logic [127:0] maxv, cap, t1, t2, tn, w1, w2, wn;
    bit          ov;
    exp_t        e;
    w    = sel ? 8 : 32;
    maxv = (128'd1 << w) - 128'd1;
    cap  = 128'd1 << 100;
    t1 = 0; t2 = 0; w1 = 0; w2 = 0;
    ov  = 1'b0;
    len = 0;
    for (int k = 1; k <= n; k++) begin
      if (k <= 2) begin
        tn = 128'd1;
        wn = 128'd1;
      end else begin
        tn = t1 + t2;
        if (tn > cap) tn = cap;
        wn = (w1 + w2) & maxv;
      end
      t2 = t1; t1 = tn;
      w2 = w1; w1 = wn;
      if (tn > maxv) ov = 1'b1;
`ifdef FIBONACCI_STREAM_SAT_EN
      if (ov) begin
        e.d = maxv[31:0]; e.l = 1'b1; e.o = 1'b1;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        len++;
        break;
      end
`endif
      e.d = wn[31:0]; e.l = (k == n); e.o = ov;
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
      len++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_p[0] = 1'b0;
      stall_p[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (valid[i] && stall_p[i]) begin
          chk("hold_data", dat[i], held_d[i]);
          chk("hold_last", last[i], held_l[i]);
        end
        if (valid[i] && ready[i]) begin
          beats[i]++;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            if (i == 0) mon_e = q0.pop_front(); else mon_e = q1.pop_front();
            chk(i == 0 ? "data32" : "data8", dat[i], mon_e.d);
            chk(i == 0 ? "last32" : "last8", last[i], mon_e.l);
            chk(i == 0 ? "ovf32" : "ovf8", ovf[i], mon_e.o);
          end
        end
        stall_p[i] = valid[i] && !ready[i];
        held_d[i]  = dat[i];
        held_l[i]  = last[i];
      end
    end
  end

  // mode 0: ready always high; 1: random backpressure; 2: stall three cycles while term 2 is shown
  task automatic do_seq(int sel, int n, int mode, bit inject);
    int len, b0, cyc, stalls;
    model_push(sel, n, len);
    b0 = beats[sel];
    @(posedge clk); #1;
    start[sel] = 1'b1; nt[sel] = n[7:0]; ready[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    cyc = 1; stalls = 0;
    while (busy[sel] && cyc < 4000) begin
      case (mode)
        1: ready[sel] = ($urandom_range(0, 3) != 0);
        2: begin
          if (valid[sel] && dat[sel] == 32'd2 && stalls < 3) begin
            ready[sel] = 1'b0;
            stalls++;
          end else begin
            ready[sel] = 1'b1;
          end
        end
        default: ready[sel] = 1'b1;
      endcase
      if (inject && cyc == 3) begin
        start[sel] = 1'b1; nt[sel] = 8'd2;
      end else begin
        start[sel] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start[sel] = 1'b0;
    ready[sel] = 1'b1;
    chk("seq_timeout", busy[sel], 0);
    chk("beat_count", beats[sel] - b0, len);
    if (mode == 0 && len > 0) chk("no_bubble", cyc, len + 1);
    if (mode == 2) chk("stall_cycles", stalls, 3);
    chk("sb_empty", (sel == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, sel, n, mode, len;
    rst = 1'b1;
    beats[0] = 0; beats[1] = 0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; nt[i] = 8'd0; ready[i] = 1'b1;
    end
    #2;
    chk("rst_valid", valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_last", last[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_data", dat[0], 0);
    #10 rst = 1'b0;

    do_seq(0, 10, 0, 1'b0);
    do_seq(0, 6, 2, 1'b0);

    b = beats[1];
    do_seq(1, 16, 0, 1'b0);
`ifdef FIBONACCI_STREAM_SAT_EN
    chk("w8_total_beats", beats[1] - b, 14);
`else
    chk("w8_total_beats", beats[1] - b, 16);
`endif
    chk("w8_ovf_sticky", ovf[1], 1);
    do_seq(1, 5, 1, 1'b0);
    chk("ovf_cleared", ovf[1], 0);

    b = beats[0];
    @(posedge clk); #1;
    start[0] = 1'b1; nt[0] = 8'd0;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("n0_busy", busy[0], 0);
      chk("n0_valid", valid[0], 0);
      @(posedge clk); #1;
    end
    chk("n0_beats", beats[0] - b, 0);

    do_seq(0, 20, 1, 1'b1);

    for (int r = 0; r < 12; r++) begin
      sel  = $urandom_range(0, 1);
      n    = $urandom_range(1, sel ? 40 : 90);
      mode = $urandom_range(0, 1);
      do_seq(sel, n, mode, r[0]);
    end

    do_seq(1, 255, 0, 1'b0);

    model_push(0, 10, len);
    @(posedge clk); #1;
    start[0] = 1'b1; nt[0] = 8'd10; ready[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    b = beats[0];
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_beats_before", beats[0] - b, 4);
    chk("arst_valid", valid[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_last", last[0], 0);
    chk("arst_data", dat[0], 0);
    chk("arst_ovf32", ovf[0], 0);
    chk("arst_ovf8", ovf[1], 0);
    q0.delete();
    q1.delete();
    @(posedge clk); #3 rst = 1'b0;
    do_seq(0, 3, 0, 1'b0);
    chk("post_rst_ovf", ovf[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
